// File: rtl/vm_pkg.sv
// Shared types and elaboration helpers for the parametrised vending controller.
package vm_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    DROP    = 3'd2,
    CHANGE  = 3'd3,
    REFUND  = 3'd4
  } vm_state_t;

  typedef enum logic [2:0] {
    CR_HOLD      = 3'd0,
    CR_ADD       = 3'd1,
    CR_SUB_PRICE = 3'd2,
    CR_SUB_UNIT  = 3'd3,
    CR_CLEAR     = 3'd4
  } cr_op_t;

  function automatic bit is_multiple(input int unsigned value, input int unsigned unit);
    return (unit != 0) && ((value % unit) == 0);
  endfunction

  function automatic bit fits_width(input int unsigned value, input int unsigned width);
    return (width >= 32) || ((value >> width) == 0);
  endfunction

endpackage

// File: rtl/vending_machine_param_if.sv
// Coin-acceptor / actuator bus between the front end and the vending controller.
interface vending_machine_param_if #(
  parameter int unsigned CREDIT_W = 8
);
  logic                coin0_in;
  logic                coin1_in;
  logic                cancel_in;
  logic                drop_out;
  logic                change_out;
  logic                refund_out;
  logic                coin_reject;
  logic                busy;
  logic [CREDIT_W-1:0] credit_out;

  modport master (
    output coin0_in, coin1_in, cancel_in,
    input  drop_out, change_out, refund_out, coin_reject, busy, credit_out
  );

  modport slave (
    input  coin0_in, coin1_in, cancel_in,
    output drop_out, change_out, refund_out, coin_reject, busy, credit_out
  );
endinterface

// File: rtl/vm_credit_unit.sv
// Credit register with add/subtract/clear operations and the compares the FSM steers on.
module vm_credit_unit
  import vm_pkg::*;
#(
  parameter int unsigned CREDIT_W    = 8,
  parameter int unsigned PRICE       = 150,
  parameter int unsigned CHANGE_UNIT = 50,
  parameter int unsigned MAX_CREDIT  = 250
) (
  input  logic                clk,
  input  logic                rst,
  input  cr_op_t              op_i,
  input  logic [CREDIT_W-1:0] coin_val_i,
  output logic [CREDIT_W-1:0] credit_o,
  output logic                sum_over_max_o,
  output logic                sum_hits_price_o,
  output logic                price_exact_o,
  output logic                last_unit_o
);

  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [31:0]         sum;

  // Compares run at 32 bits so PRICE may exceed what the credit register can hold.
  assign sum              = 32'(credit_q) + 32'(coin_val_i);
  assign sum_over_max_o   = sum > MAX_CREDIT;
  assign sum_hits_price_o = sum >= PRICE;
  assign price_exact_o    = 32'(credit_q) == PRICE;
  assign last_unit_o      = 32'(credit_q) == CHANGE_UNIT;
  assign credit_o         = credit_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    credit_d = credit_q;
    case (op_i)
      CR_ADD:       credit_d = CREDIT_W'(sum);
      CR_SUB_PRICE: credit_d = CREDIT_W'(32'(credit_q) - PRICE);
      CR_SUB_UNIT:  credit_d = CREDIT_W'(32'(credit_q) - CHANGE_UNIT);
      CR_CLEAR:     credit_d = '0;
      default:      credit_d = credit_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) credit_q <= '0;
    else     credit_q <= credit_d;
  end

endmodule

// File: rtl/vending_machine_param.sv
// Vending controller FSM: coin acceptance, dispense, change and refund pulse trains.
module vending_machine_param
  import vm_pkg::*;
#(
  parameter int unsigned CREDIT_W    = 8,
  parameter int unsigned PRICE       = 150,
  parameter int unsigned COIN0_VAL   = 50,
  parameter int unsigned COIN1_VAL   = 100,
  parameter int unsigned CHANGE_UNIT = 50,
  parameter int unsigned MAX_CREDIT  = 250
) (
  input  logic                    clk,
  input  logic                    reset,
  vending_machine_param_if.slave  bus
);

  if (!is_multiple(PRICE, CHANGE_UNIT) || !is_multiple(COIN0_VAL, CHANGE_UNIT) ||
      !is_multiple(COIN1_VAL, CHANGE_UNIT)) begin : g_bad_unit
    $error("PRICE and coin values must be multiples of CHANGE_UNIT");
  end
  if (!fits_width(MAX_CREDIT, CREDIT_W) || !fits_width(COIN0_VAL, CREDIT_W) ||
      !fits_width(COIN1_VAL, CREDIT_W)) begin : g_bad_width
    $error("MAX_CREDIT and coin values must fit in CREDIT_W bits");
  end

  vm_state_t           state_q, state_d;
  cr_op_t              cr_op;
  logic                coin_reject_q, coin_reject_d;
  logic [CREDIT_W-1:0] coin_val, credit;
  logic                sum_over_max, sum_hits_price, price_exact, last_unit;
  logic                coin_any, coin_both;

  assign coin_any  = bus.coin0_in | bus.coin1_in;
  assign coin_both = bus.coin0_in & bus.coin1_in;
  assign coin_val  = bus.coin1_in ? CREDIT_W'(COIN1_VAL) : CREDIT_W'(COIN0_VAL);

  vm_credit_unit #(
    .CREDIT_W    (CREDIT_W),
    .PRICE       (PRICE),
    .CHANGE_UNIT (CHANGE_UNIT),
    .MAX_CREDIT  (MAX_CREDIT)
  ) u_credit (
    .clk              (clk),
    .rst              (reset),
    .op_i             (cr_op),
    .coin_val_i       (coin_val),
    .credit_o         (credit),
    .sum_over_max_o   (sum_over_max),
    .sum_hits_price_o (sum_hits_price),
    .price_exact_o    (price_exact),
    .last_unit_o      (last_unit)
  );

  always_comb begin
    state_d       = state_q;
    cr_op         = CR_HOLD;
    coin_reject_d = 1'b0;
    case (state_q)
      IDLE, COLLECT: begin
        if (coin_any && (coin_both || bus.cancel_in || sum_over_max)) begin
          coin_reject_d = 1'b1;
        end else if (coin_any) begin
          cr_op   = CR_ADD;
          state_d = sum_hits_price ? DROP : COLLECT;
        end
        // Cancel wins over a coin; an empty machine has nothing to refund.
        if (bus.cancel_in && (state_q == COLLECT || credit != '0)) begin
          cr_op   = CR_HOLD;
          state_d = REFUND;
        end
      end
      DROP: begin
        coin_reject_d = coin_any;
        cr_op         = CR_SUB_PRICE;
        state_d       = price_exact ? IDLE : CHANGE;
      end
      CHANGE, REFUND: begin
        coin_reject_d = coin_any;
        if (last_unit) begin
          cr_op   = CR_CLEAR;
          state_d = IDLE;
        end else begin
          cr_op   = CR_SUB_UNIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      coin_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      coin_reject_q <= coin_reject_d;
    end
  end

  assign bus.drop_out    = state_q == DROP;
  assign bus.change_out  = (state_q == CHANGE) || (state_q == REFUND);
  assign bus.refund_out  = state_q == REFUND;
  assign bus.busy        = (state_q == DROP) || (state_q == CHANGE) || (state_q == REFUND);
  assign bus.coin_reject = coin_reject_q;
  assign bus.credit_out  = credit;

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed bench for vending_machine_param: default build plus a PRICE=300 override build.
module tb_vending_machine_param;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  vending_machine_param_if #(.CREDIT_W(8)) bus  ();
  vending_machine_param_if #(.CREDIT_W(8)) bus2 ();

  vending_machine_param dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  vending_machine_param #(
    .PRICE      (300),
    .MAX_CREDIT (250)
  ) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c0, input logic c1, input logic cn);
    bus.coin0_in  = c0;
    bus.coin1_in  = c1;
    bus.cancel_in = cn;
    tick();
    bus.coin0_in  = 1'b0;
    bus.coin1_in  = 1'b0;
    bus.cancel_in = 1'b0;
  endtask

  task automatic drive2(input logic c0, input logic c1, input logic cn);
    bus2.coin0_in  = c0;
    bus2.coin1_in  = c1;
    bus2.cancel_in = cn;
    tick();
    bus2.coin0_in  = 1'b0;
    bus2.coin1_in  = 1'b0;
    bus2.cancel_in = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && bus.busy; i++) tick();
  endtask

  task automatic test_reset();
    tests_run++;
    if ({bus.drop_out, bus.change_out, bus.refund_out, bus.coin_reject, bus.busy} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {bus.drop_out, bus.change_out, bus.refund_out, bus.coin_reject, bus.busy});
    end
    tests_run++;
    if (bus.credit_out !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_credit: got %0d expected 0", bus.credit_out);
    end
  endtask

  task automatic test_exact_price();
    drive(1'b1, 1'b0, 1'b0);
    tests_run++;
    if (bus.credit_out !== 8'd50 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL exact_coin0: credit %0d busy %b expected 50 0", bus.credit_out, bus.busy);
    end
    tick();
    tick();
    drive(1'b0, 1'b1, 1'b0);
    tests_run++;
    if (bus.credit_out !== 8'd150 || bus.drop_out !== 1'b1 || bus.change_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL exact_drop: credit %0d drop %b change %b expected 150 1 0",
               bus.credit_out, bus.drop_out, bus.change_out);
    end
    tick();
    tests_run++;
    if (bus.drop_out !== 1'b0 || bus.change_out !== 1'b0 || bus.busy !== 1'b0 ||
        bus.credit_out !== 8'd0) begin
      tests_failed++;
      $display("FAIL exact_idle: drop %b change %b busy %b credit %0d expected 0 0 0 0",
               bus.drop_out, bus.change_out, bus.busy, bus.credit_out);
    end
  endtask

  task automatic test_change();
    int drops, changes, refunds;
    drops = 0; changes = 0; refunds = 0;
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    tests_run++;
    if (bus.credit_out !== 8'd200 || bus.drop_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL change_drop: credit %0d drop %b expected 200 1", bus.credit_out, bus.drop_out);
    end
    for (int i = 0; i < 6; i++) begin
      drops   += int'(bus.drop_out);
      changes += int'(bus.change_out);
      refunds += int'(bus.change_out & bus.refund_out);
      tick();
    end
    tests_run++;
    if (drops != 1 || changes != 1 || refunds != 0) begin
      tests_failed++;
      $display("FAIL change_pulses: drops %0d changes %0d refunds %0d expected 1 1 0",
               drops, changes, refunds);
    end
    tests_run++;
    if (bus.credit_out !== 8'd0) begin
      tests_failed++;
      $display("FAIL change_credit: got %0d expected 0", bus.credit_out);
    end
  endtask

  task automatic test_cancel();
    int drops, changes, refunds;
    drops = 0; changes = 0; refunds = 0;
    drive(1'b0, 1'b0, 1'b1);
    tests_run++;
    if (bus.busy !== 1'b0 || bus.refund_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL cancel_empty: busy %b refund %b expected 0 0", bus.busy, bus.refund_out);
    end
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    tests_run++;
    if (bus.refund_out !== 1'b1 || bus.change_out !== 1'b1 || bus.credit_out !== 8'd50) begin
      tests_failed++;
      $display("FAIL cancel_refund: refund %b change %b credit %0d expected 1 1 50",
               bus.refund_out, bus.change_out, bus.credit_out);
    end
    for (int i = 0; i < 5; i++) begin
      drops   += int'(bus.drop_out);
      changes += int'(bus.change_out);
      refunds += int'(bus.change_out & bus.refund_out);
      tick();
    end
    tests_run++;
    if (drops != 0 || changes != 1 || refunds != 1 || bus.credit_out !== 8'd0) begin
      tests_failed++;
      $display("FAIL cancel_pulses: drops %0d changes %0d refunds %0d credit %0d expected 0 1 1 0",
               drops, changes, refunds, bus.credit_out);
    end
  endtask

  task automatic test_reject();
    drive(1'b1, 1'b1, 1'b0);
    tests_run++;
    if (bus.coin_reject !== 1'b1 || bus.credit_out !== 8'd0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reject_both: reject %b credit %0d busy %b expected 1 0 0",
               bus.coin_reject, bus.credit_out, bus.busy);
    end
    tick();
    tests_run++;
    if (bus.coin_reject !== 1'b0) begin
      tests_failed++;
      $display("FAIL reject_width: got %b expected 0", bus.coin_reject);
    end
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    tests_run++;
    if (bus.coin_reject !== 1'b1 || bus.credit_out !== 8'd0 || bus.busy !== 1'b0 ||
        bus.change_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL reject_busy: reject %b credit %0d busy %b change %b expected 1 0 0 0",
               bus.coin_reject, bus.credit_out, bus.busy, bus.change_out);
    end
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    tests_run++;
    if (bus.coin_reject !== 1'b1 || bus.refund_out !== 1'b1 || bus.credit_out !== 8'd50) begin
      tests_failed++;
      $display("FAIL reject_cancel: reject %b refund %b credit %0d expected 1 1 50",
               bus.coin_reject, bus.refund_out, bus.credit_out);
    end
    drain();
  endtask

  task automatic test_price_override();
    int changes;
    changes = 0;
    drive2(1'b0, 1'b1, 1'b0);
    drive2(1'b0, 1'b1, 1'b0);
    drive2(1'b0, 1'b1, 1'b0);
    tests_run++;
    if (bus2.coin_reject !== 1'b1 || bus2.credit_out !== 8'd200 || bus2.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL override_max: reject %b credit %0d busy %b expected 1 200 0",
               bus2.coin_reject, bus2.credit_out, bus2.busy);
    end
    drive2(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      changes += int'(bus2.change_out & bus2.refund_out);
      tick();
    end
    tests_run++;
    if (changes != 4 || bus2.credit_out !== 8'd0 || bus2.drop_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL override_refund: pulses %0d credit %0d drop %b expected 4 0 0",
               changes, bus2.credit_out, bus2.drop_out);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    tick();
    tests_run++;
    if (bus.change_out !== 1'b1 || bus.credit_out !== 8'd50) begin
      tests_failed++;
      $display("FAIL async_pre: change %b credit %0d expected 1 50", bus.change_out, bus.credit_out);
    end
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if ({bus.drop_out, bus.change_out, bus.refund_out, bus.coin_reject, bus.busy} !== 5'b0 ||
        bus.credit_out !== 8'd0) begin
      tests_failed++;
      $display("FAIL async_reset: outputs %b credit %0d expected 00000 0",
               {bus.drop_out, bus.change_out, bus.refund_out, bus.coin_reject, bus.busy},
               bus.credit_out);
    end
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0);
    tests_run++;
    if (bus.credit_out !== 8'd50 || bus.coin_reject !== 1'b0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_after: credit %0d reject %b busy %b expected 50 0 0",
               bus.credit_out, bus.coin_reject, bus.busy);
    end
    drive(1'b0, 1'b0, 1'b1);
    drain();
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    reset          = 1'b1;
    bus.coin0_in   = 1'b0;
    bus.coin1_in   = 1'b0;
    bus.cancel_in  = 1'b0;
    bus2.coin0_in  = 1'b0;
    bus2.coin1_in  = 1'b0;
    bus2.cancel_in = 1'b0;
    #12;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    tick();
    test_exact_price();
    test_change();
    test_cancel();
    test_reject();
    test_price_override();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
